// File: rtl/gamma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gamma_pkg
//  Description : Shared constants and helpers for the gamma/tone-curve stage:
//                LUT channel selects, AXI4-Stream sideband widths, the padded
//                TDATA width, and the per-channel bit offset inside TDATA.
//  Revision    : 1.0  initial release
// ============================================================================
package gamma_pkg;

   localparam logic [1:0] CH_R   = 2'd0;
   localparam logic [1:0] CH_G   = 2'd1;
   localparam logic [1:0] CH_B   = 2'd2;
   localparam logic [1:0] CH_ALL = 2'd3;

   localparam int AXIS_ID_WIDTH   = 4;
   localparam int AXIS_DEST_WIDTH = 4;

   // Three components packed, rounded up to a whole number of bytes.
   function automatic int tdata_width(input int px_width);
      return ((3 * px_width + 7) / 8) * 8;
   endfunction

   // Bit offset of a channel in TDATA: R on top, B in the middle, G at the bottom.
   function automatic int ch_lsb(input logic [1:0] ch, input int px_width);
      case (ch)
         CH_R:    return 2 * px_width;
         CH_B:    return px_width;
         default: return 0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_stream_if
//  Description : AXI4-Stream bundle with master/slave modports.
//  Revision    : 1.0  initial release
// ============================================================================
interface axi4_stream_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int DEST_WIDTH = 4
);
   logic                    tvalid;
   logic                    tready;
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;
   logic                    tuser;
   logic [ID_WIDTH-1:0]     tid;
   logic [DEST_WIDTH-1:0]   tdest;

   modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                   input  tready);
   modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                   output tready);
endinterface
`default_nettype wire

// File: rtl/gamma_lut_ram.sv
`default_nettype none
// ============================================================================
//  Module      : gamma_lut_ram
//  Description : Simple dual-port RAM for one colour channel. The address MSB
//                selects the bank; the read port is registered with an enable
//                so it can stall with the pipeline. The array is never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module gamma_lut_ram #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);
   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Software write port.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   // Registered read port, held while the consuming stage is stalled.
   always_ff @(posedge clk_i) begin
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;
endmodule
`default_nettype wire

// File: rtl/gamma_corrector.sv
`default_nettype none
// ============================================================================
//  Module      : gamma_corrector
//  Description : Per-channel gamma LUT on an RGB AXI4-Stream. Double-buffered
//                LUTs swap on the first start-of-frame beat after a request.
//                Two-stage pipeline with full backpressure support.
//  Revision    : 1.0  initial release
// ============================================================================
module gamma_corrector
   import gamma_pkg::*;
#(
   parameter int PX_WIDTH = 10
) (
   input  logic                clk_i,
   input  logic                rst_i,
   axi4_stream_if.slave        video_i,
   axi4_stream_if.master       video_o,
   input  logic                bypass_i,
   input  logic                lut_wr_i,
   input  logic [1:0]          lut_ch_i,
   input  logic [PX_WIDTH-1:0] lut_addr_i,
   input  logic [PX_WIDTH-1:0] lut_data_i,
   output logic                lut_ready_o,
   input  logic                lut_swap_i,
   output logic                lut_swap_pending_o,
   output logic                lut_active_bank_o
);
   localparam int TDATA_WIDTH = tdata_width(PX_WIDTH);
   localparam int KEEP_WIDTH  = TDATA_WIDTH / 8;
   localparam int PIX_WIDTH   = 3 * PX_WIDTH;
   localparam int SB_WIDTH    = 2 + 2 * KEEP_WIDTH + AXIS_ID_WIDTH + AXIS_DEST_WIDTH;

   logic active_q, active_d, pending_q, pending_d, loaded_q, loaded_d;

   logic                 s1_valid_q, s1_bank_q, s1_ident_q;
   logic [PIX_WIDTH-1:0] s1_pix_q;
   logic [SB_WIDTH-1:0]  s1_sb_q;
   logic                 s2_valid_q, s2_ident_q;
   logic [PIX_WIDTH-1:0] s2_pix_q;
   logic [SB_WIDTH-1:0]  s2_sb_q;

   logic                 s1_ready, s2_ready, in_accept, swap_on_beat, sof_swap;
   logic                 rd_bank, ident_in;
   logic [SB_WIDTH-1:0]  sb_in;
   logic [PIX_WIDTH-1:0] lut_px, px_out;

   assign s2_ready      = video_o.tready || !s2_valid_q;
   assign s1_ready      = s2_ready || !s1_valid_q;
   assign video_i.tready = s1_ready;
   assign in_accept     = video_i.tvalid && s1_ready;

   // A SOF beat arriving while a swap is pending already belongs to the new curve.
   assign swap_on_beat  = pending_q && video_i.tuser;
   assign sof_swap      = in_accept && swap_on_beat;
   assign rd_bank       = swap_on_beat ? !active_q : active_q;
   assign ident_in      = bypass_i || !(loaded_q || swap_on_beat);
   assign sb_in         = {video_i.tuser, video_i.tlast, video_i.tstrb, video_i.tkeep,
                           video_i.tid, video_i.tdest};

   assign lut_ready_o        = !pending_q;
   assign lut_swap_pending_o = pending_q;
   assign lut_active_bank_o  = active_q;

   // Bank control: a request stays pending until the next accepted SOF beat.
   always_comb begin
      active_d  = active_q;
      pending_d = pending_q;
      loaded_d  = loaded_q;
      if (sof_swap) begin
         active_d  = !active_q;
         pending_d = 1'b0;
         loaded_d  = 1'b1;
      end else if (lut_swap_i) begin
         pending_d = 1'b1;
      end
   end

   // Bank control state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active_q  <= 1'b0;
         pending_q <= 1'b0;
         loaded_q  <= 1'b0;
      end else begin
         active_q  <= active_d;
         pending_q <= pending_d;
         loaded_q  <= loaded_d;
      end
   end

   // Stage 1: capture the beat, its read bank and whether it passes untouched.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_bank_q  <= 1'b0;
         s1_ident_q <= 1'b1;
         s1_pix_q   <= '0;
         s1_sb_q    <= '0;
      end else if (s1_ready) begin
         s1_valid_q <= video_i.tvalid;
         s1_bank_q  <= rd_bank;
         s1_ident_q <= ident_in;
         s1_pix_q   <= video_i.tdata[PIX_WIDTH-1:0];
         s1_sb_q    <= sb_in;
      end
   end

   // Stage 2: runs in lockstep with the RAM read registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s2_valid_q <= 1'b0;
         s2_ident_q <= 1'b1;
         s2_pix_q   <= '0;
         s2_sb_q    <= '0;
      end else if (s2_ready) begin
         s2_valid_q <= s1_valid_q;
         s2_ident_q <= s1_ident_q;
         s2_pix_q   <= s1_pix_q;
         s2_sb_q    <= s1_sb_q;
      end
   end

   for (genvar c = 0; c < 3; c++) begin : g_ch
      localparam int LSB = ch_lsb(2'(c), PX_WIDTH);
      logic wr_en;
      assign wr_en = lut_wr_i && !pending_q && (lut_ch_i == 2'(c) || lut_ch_i == CH_ALL);

      gamma_lut_ram #(
         .ADDR_WIDTH (PX_WIDTH + 1),
         .DATA_WIDTH (PX_WIDTH)
      ) u_ram (
         .clk_i     (clk_i),
         .wr_en_i   (wr_en),
         .wr_addr_i ({!active_q, lut_addr_i}),
         .wr_data_i (lut_data_i),
         .rd_en_i   (s2_ready),
         .rd_addr_i ({s1_bank_q, s1_pix_q[LSB +: PX_WIDTH]}),
         .rd_data_o (lut_px[LSB +: PX_WIDTH])
      );
   end

   assign px_out         = s2_ident_q ? s2_pix_q : lut_px;
   assign video_o.tvalid = s2_valid_q;
   assign video_o.tdata  = TDATA_WIDTH'(px_out);
   assign {video_o.tuser, video_o.tlast, video_o.tstrb, video_o.tkeep,
           video_o.tid, video_o.tdest} = s2_sb_q;
endmodule
`default_nettype wire

// File: tb/tb_gamma_corrector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gamma_corrector
//  Description : Self-checking bench for gamma_corrector: directed vector
//                table plus hand-written swap, backpressure and reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gamma_corrector;
   import gamma_pkg::*;

   localparam int P  = 10;
   localparam int TW = 32;

   typedef struct {
      logic [P-1:0] r, g, b;
      logic         user, last, byp, swp;
      logic [P-1:0] er, eg, eb;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [5:0]  side;
   } exp_t;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         bypass_i = 1'b0, lut_wr_i = 1'b0, lut_swap_i = 1'b0;
   logic [1:0]   lut_ch_i = 2'd0;
   logic [P-1:0] lut_addr_i = '0, lut_data_i = '0;
   logic         lut_ready_o, lut_swap_pending_o, lut_active_bank_o;
   logic         rand_rdy = 1'b0;
   logic [3:0]   tid_cnt = 4'd0;

   int   tests = 0;
   int   fails = 0;
   vec_t vec [16];
   exp_t exp_q [$];
   exp_t mon_e;

   axi4_stream_if #(.DATA_WIDTH(TW)) in_if ();
   axi4_stream_if #(.DATA_WIDTH(TW)) out_if ();

   gamma_corrector #(.PX_WIDTH(P)) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .video_i            (in_if),
      .video_o            (out_if),
      .bypass_i           (bypass_i),
      .lut_wr_i           (lut_wr_i),
      .lut_ch_i           (lut_ch_i),
      .lut_addr_i         (lut_addr_i),
      .lut_data_i         (lut_data_i),
      .lut_ready_o        (lut_ready_o),
      .lut_swap_i         (lut_swap_i),
      .lut_swap_pending_o (lut_swap_pending_o),
      .lut_active_bank_o  (lut_active_bank_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] pack(input logic [P-1:0] r, g, b);
      return {2'b00, r, b, g};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Output scoreboard: every transferred beat is checked against the queue.
   always @(negedge clk_i) begin
      if (!rst_i && out_if.tvalid && out_if.tready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got 0x%0h with no beat expected", out_if.tdata);
         end else begin
            tests--;
            mon_e = exp_q.pop_front();
            check("tdata", out_if.tdata, mon_e.data);
            check("sideband", {26'd0, out_if.tuser, out_if.tlast, out_if.tid}, {26'd0, mon_e.side});
         end
      end
   end

   // Random output backpressure when enabled.
   always @(posedge clk_i) begin
      #1;
      if (rand_rdy) out_if.tready = 1'($urandom_range(0, 1));
   end

   task automatic send_beat(input logic [P-1:0] r, g, b, input logic u, l, byp, swp,
                            input logic [31:0] exp);
      int   n = 0;
      exp_t e;
      in_if.tdata  = pack(r, g, b);
      in_if.tuser  = u;
      in_if.tlast  = l;
      in_if.tid    = tid_cnt;
      in_if.tvalid = 1'b1;
      bypass_i     = byp;
      lut_swap_i   = swp;
      @(negedge clk_i);
      while (!in_if.tready && n < 1000) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 1000) begin
         tests++;
         fails++;
         $display("FAIL input_accept_timeout: tready stuck at %0b", in_if.tready);
      end
      step();
      e.data = exp;
      e.side = {u, l, tid_cnt};
      exp_q.push_back(e);
      tid_cnt++;
      in_if.tvalid = 1'b0;
      bypass_i     = 1'b0;
      lut_swap_i   = 1'b0;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         send_beat(vec[i].r, vec[i].g, vec[i].b, vec[i].user, vec[i].last, vec[i].byp,
                   vec[i].swp, pack(vec[i].er, vec[i].eg, vec[i].eb));
   endtask

   task automatic write_lut(input logic [1:0] ch, input logic [P-1:0] a, d);
      lut_ch_i   = ch;
      lut_addr_i = a;
      lut_data_i = d;
      lut_wr_i   = 1'b1;
      step();
      lut_wr_i   = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: %0d beats still expected, 0 required", exp_q.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, finish required");
      $fatal(1, "watchdog");
   end

   initial begin
      //        r     g     b    u  l  byp swp   er    eg    eb
      vec[0]  = '{100,  200,  300, 1, 0, 0, 0,  100,  200,  300};
      vec[1]  = '{100,  200,  300, 0, 0, 0, 0,  100,  200,  300};
      vec[2]  = '{1023, 0,    512, 0, 1, 0, 0,  1023, 0,    512};
      vec[3]  = '{100,  200,  300, 1, 0, 0, 0,  100,  200,  300};
      vec[4]  = '{100,  200,  300, 0, 0, 0, 0,  100,  200,  300};
      vec[5]  = '{7,    8,    9,   0, 1, 0, 0,  7,    8,    9};
      vec[6]  = '{100,  200,  300, 1, 0, 0, 0,  923,  823,  723};
      vec[7]  = '{5,    5,    5,   0, 0, 0, 0,  1018, 1018, 1018};
      vec[8]  = '{0,    1023, 512, 0, 1, 0, 0,  1023, 0,    511};
      vec[9]  = '{100,  200,  300, 1, 0, 0, 1,  923,  823,  723};
      vec[10] = '{300,  100,  200, 0, 1, 0, 0,  723,  923,  823};
      vec[11] = '{100,  200,  300, 1, 0, 0, 0,  50,   100,  150};
      vec[12] = '{512,  512,  512, 0, 0, 1, 0,  512,  512,  512};
      vec[13] = '{300,  100,  200, 0, 1, 0, 0,  150,  50,   100};
      vec[14] = '{100,  200,  300, 1, 0, 0, 0,  100,  200,  300};
      vec[15] = '{300,  100,  200, 0, 1, 0, 0,  300,  100,  200};

      in_if.tvalid = 1'b0;
      in_if.tdata  = '0;
      in_if.tuser  = 1'b0;
      in_if.tlast  = 1'b0;
      in_if.tstrb  = 4'hF;
      in_if.tkeep  = 4'hF;
      in_if.tid    = '0;
      in_if.tdest  = 4'h3;
      out_if.tready = 1'b1;

      // Reset state.
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_tvalid",  {31'd0, out_if.tvalid}, 32'd0);
      check("rst_tdata",   out_if.tdata, 32'd0);
      check("rst_pending", {31'd0, lut_swap_pending_o}, 32'd0);
      check("rst_bank",    {31'd0, lut_active_bank_o}, 32'd0);
      check("rst_ready",   {31'd0, lut_ready_o}, 32'd1);
      step();
      rst_i = 1'b0;
      step();

      // Identity frame; first beat also measures latency from an empty pipe.
      run_vecs(0, 0);
      @(negedge clk_i);
      check("latency_cycle1_tvalid", {31'd0, out_if.tvalid}, 32'd0);
      @(negedge clk_i);
      check("latency_cycle2_tvalid", {31'd0, out_if.tvalid}, 32'd1);
      step();
      run_vecs(1, 2);
      drain();

      // Load the inverse curve into the shadow bank, start a frame, swap mid-frame.
      for (int a = 0; a < 1024; a++) write_lut(CH_ALL, 10'(a), 10'(1023 - a));
      run_vecs(3, 3);
      lut_swap_i = 1'b1;
      step();
      lut_swap_i = 1'b0;
      check("swap_pending_set", {31'd0, lut_swap_pending_o}, 32'd1);
      check("ready_low_pending", {31'd0, lut_ready_o}, 32'd0);
      write_lut(CH_ALL, 10'd5, 10'd7);
      check("bank_before_sof", {31'd0, lut_active_bank_o}, 32'd0);
      run_vecs(4, 6);
      check("pending_clear_at_sof", {31'd0, lut_swap_pending_o}, 32'd0);
      check("bank_after_sof", {31'd0, lut_active_bank_o}, 32'd1);
      run_vecs(7, 8);
      drain();

      // 1000 beats through the inverse curve under random backpressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         logic [P-1:0] r, g, b;
         r = 10'($urandom_range(0, 1023));
         g = 10'($urandom_range(0, 1023));
         b = 10'($urandom_range(0, 1023));
         send_beat(r, g, b, 1'b0, (i % 16) == 15, 1'b0, 1'b0,
                   pack(10'd1023 - r, 10'd1023 - g, 10'd1023 - b));
      end
      drain();
      rand_rdy = 1'b0;
      step();
      out_if.tready = 1'b1;

      // Halving curve into bank 0 for a few codes; swap pulsed with a SOF handshake.
      write_lut(CH_ALL, 10'd100, 10'd50);
      write_lut(CH_ALL, 10'd200, 10'd100);
      write_lut(CH_ALL, 10'd300, 10'd150);
      run_vecs(9, 10);
      check("swap_with_sof_deferred", {31'd0, lut_swap_pending_o}, 32'd1);
      check("bank_still_1", {31'd0, lut_active_bank_o}, 32'd1);
      run_vecs(11, 11);
      check("pending_clear_2nd", {31'd0, lut_swap_pending_o}, 32'd0);
      check("bank_back_to_0", {31'd0, lut_active_bank_o}, 32'd0);
      run_vecs(12, 13);
      drain();

      // Reset in the middle of a stalled frame.
      out_if.tready = 1'b0;
      in_if.tdata   = pack(10'd1, 10'd2, 10'd3);
      in_if.tuser   = 1'b1;
      in_if.tlast   = 1'b0;
      in_if.tvalid  = 1'b1;
      repeat (3) step();
      check("stall_out_valid", {31'd0, out_if.tvalid}, 32'd1);
      check("stall_in_ready",  {31'd0, in_if.tready}, 32'd0);
      rst_i        = 1'b1;
      in_if.tvalid = 1'b0;
      @(negedge clk_i);
      check("midframe_rst_tvalid", {31'd0, out_if.tvalid}, 32'd0);
      step();
      rst_i         = 1'b0;
      out_if.tready = 1'b1;
      check("post_rst_bank",    {31'd0, lut_active_bank_o}, 32'd0);
      check("post_rst_pending", {31'd0, lut_swap_pending_o}, 32'd0);
      check("post_rst_ready",   {31'd0, lut_ready_o}, 32'd1);
      step();
      run_vecs(14, 15);
      drain();
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
